// File: rtl/buffer_vc_fifo_cw_if.sv
// Link bundle for the clockwise-ring input buffer: upstream flit link,
// polarity, the two downstream ports (next cw router, local PE) and status.
interface buffer_vc_fifo_cw_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              polarity;
    logic              cwsi;
    logic [DATA_W-1:0] cwdi;
    logic              cwri;
    logic              cwro_cw;
    logic              write_en_cw;
    logic              cwro_pe;
    logic              write_en_pe;
    logic              cwso_cw;
    logic              cwso_pe;
    logic [DATA_W-1:0] cwdo_even;
    logic [DATA_W-1:0] cwdo_odd;
    logic [CNT_W-1:0]  count_even;
    logic [CNT_W-1:0]  count_odd;
    logic              proto_err;

    // Buffer side of the link.
    modport slave (
        input  polarity, cwsi, cwdi, cwro_cw, write_en_cw, cwro_pe, write_en_pe,
        output cwri, cwso_cw, cwso_pe, cwdo_even, cwdo_odd,
               count_even, count_odd, proto_err
    );

    // Environment side: upstream router, downstream arbiters and observers.
    modport master (
        output polarity, cwsi, cwdi, cwro_cw, write_en_cw, cwro_pe, write_en_pe,
        input  cwri, cwso_cw, cwso_pe, cwdo_even, cwdo_odd,
               count_even, count_odd, proto_err
    );
endinterface

// File: rtl/buffer_vc_fifo_cw.sv
// Clockwise-ring input buffer with two virtual channels (index 0 = even,
// index 1 = odd), each a DEPTH-entry circular FIFO. Polarity picks the VC
// written from upstream and the VC drained this cycle; they always differ,
// so no FIFO is ever read and written in the same cycle.
//
// Handshakes: a flit transfers upstream on a clock edge where cwsi && cwri.
// Downstream, cwso_cw / cwso_pe is the request (valid) and already includes
// the port's ready (cwro_*); the head is removed on an edge where a request
// is high together with its matching grant write_en_*. cwsi while cwri is
// low drops the flit and sets the sticky proto_err.
module buffer_vc_fifo_cw #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4,
    parameter int DIR_BIT = 48
) (
    input  logic                   clk,
    input  logic                   reset,
    buffer_vc_fifo_cw_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q    [2][DEPTH];
    logic [DATA_W-1:0] mem_d    [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  count_q  [2];
    logic [CNT_W-1:0]  count_d  [2];
    logic              proto_err_q;
    logic              proto_err_d;

    logic              wv;
    logic              rv;
    logic              wv_full;
    logic              rv_has;
    logic [DATA_W-1:0] head;
    logic              so_cw;
    logic              so_pe;
    logic              push;
    logic              pop;

    // Decode write/read VC from polarity and form requests from the read-VC head.
    always_comb begin
        wv      = ~bus.polarity;
        rv      = bus.polarity;
        wv_full = (count_q[wv] == CNT_W'(DEPTH));
        rv_has  = (count_q[rv] != '0);
        head    = mem_q[rv][rd_ptr_q[rv]];
        so_cw   = rv_has && bus.cwro_cw && head[DIR_BIT];
        so_pe   = rv_has && bus.cwro_pe && !head[DIR_BIT];
        push    = bus.cwsi && !wv_full;
        pop     = (so_cw && bus.write_en_cw) || (so_pe && bus.write_en_pe);
    end

    assign bus.cwri       = !wv_full;
    assign bus.cwso_cw    = so_cw;
    assign bus.cwso_pe    = so_pe;
    assign bus.cwdo_even  = (count_q[0] != '0) ? mem_q[0][rd_ptr_q[0]] : '0;
    assign bus.cwdo_odd   = (count_q[1] != '0) ? mem_q[1][rd_ptr_q[1]] : '0;
    assign bus.count_even = count_q[0];
    assign bus.count_odd  = count_q[1];
    assign bus.proto_err  = proto_err_q;

    // Next state: push into the write VC tail, pop the read VC head, flag overflow.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        proto_err_d = proto_err_q | (bus.cwsi && wv_full);
        if (push) begin
            mem_d[wv][wr_ptr_q[wv]] = bus.cwdi;
            wr_ptr_d[wv]            = wr_ptr_q[wv] + 1'b1;
            count_d[wv]             = count_q[wv] + 1'b1;
        end
        if (pop) begin
            rd_ptr_d[rv] = rd_ptr_q[rv] + 1'b1;
            count_d[rv]  = count_q[rv] - 1'b1;
        end
    end

    // State registers; reset discards every queued flit immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '{default: '0};
            rd_ptr_q    <= '{default: '0};
            count_q     <= '{default: '0};
            proto_err_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_buffer_vc_fifo_cw.sv
// Bench for buffer_vc_fifo_cw: directed vectors, per-VC expected queues,
// negedge monitor comparing heads, requests, counts and popped flits.
module tb_buffer_vc_fifo_cw;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 4;
    localparam int DIR_BIT = 48;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    buffer_vc_fifo_cw_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    buffer_vc_fifo_cw #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIR_BIT(DIR_BIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] exp_q_even [$];
    logic [DATA_W-1:0] exp_q_odd  [$];
    int   checks = 0;
    int   errors = 0;
    logic pend_acc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic dir, input logic [15:0] tag);
        logic [63:0] f;
        f = 64'hC0DE_0000_0000_0000 | {48'd0, tag};
        f[DIR_BIT] = dir;
        return f;
    endfunction

    // Monitor: compare visible heads, requests and occupancy, then retire popped flits.
    always @(negedge clk) begin : mon
        logic [63:0] h_e, h_o, hd;
        logic has_e, has_o, has, exp_cw, exp_pe, exp_ri;
        int   wsize;
        if (!reset) begin
            has_e = (exp_q_even.size() != 0);
            has_o = (exp_q_odd.size() != 0);
            h_e   = has_e ? exp_q_even[0] : 64'd0;
            h_o   = has_o ? exp_q_odd[0]  : 64'd0;
            check("count_even", 64'(bus.count_even), 64'(exp_q_even.size()));
            check("count_odd",  64'(bus.count_odd),  64'(exp_q_odd.size()));
            check("cwdo_even", bus.cwdo_even, h_e);
            check("cwdo_odd",  bus.cwdo_odd,  h_o);
            has    = bus.polarity ? has_o : has_e;
            hd     = bus.polarity ? h_o : h_e;
            wsize  = bus.polarity ? exp_q_even.size() : exp_q_odd.size();
            exp_ri = (wsize != DEPTH);
            exp_cw = has && bus.cwro_cw && hd[DIR_BIT];
            exp_pe = has && bus.cwro_pe && !hd[DIR_BIT];
            check("cwri",    64'(bus.cwri),    64'(exp_ri));
            check("cwso_cw", 64'(bus.cwso_cw), 64'(exp_cw));
            check("cwso_pe", 64'(bus.cwso_pe), 64'(exp_pe));
            if ((exp_cw && bus.write_en_cw) || (exp_pe && bus.write_en_pe)) begin
                if (bus.polarity) void'(exp_q_odd.pop_front());
                else              void'(exp_q_even.pop_front());
            end
        end
    end

    task automatic drive(input logic pol, input logic si, input logic [63:0] di, input logic acc,
                         input logic crdy, input logic cen, input logic prdy, input logic pen);
        bus.polarity    = pol;
        bus.cwsi        = si;
        bus.cwdi        = di;
        bus.cwro_cw     = crdy;
        bus.write_en_cw = cen;
        bus.cwro_pe     = prdy;
        bus.write_en_pe = pen;
        pend_acc        = acc;
    endtask

    // One clock: expected push recorded at the edge the DUT stores it.
    task automatic tick();
        @(posedge clk);
        if (bus.cwsi && pend_acc) begin
            if (bus.polarity) exp_q_even.push_back(bus.cwdi);
            else              exp_q_odd.push_back(bus.cwdi);
        end
        #1;
    endtask

    task automatic cyc(input logic pol, input logic si, input logic [63:0] di, input logic acc,
                       input logic crdy, input logic cen, input logic prdy, input logic pen);
        drive(pol, si, di, acc, crdy, cen, prdy, pen);
        tick();
    endtask

    localparam logic [63:0] F1 = 64'hAAA1_AAAA_AAAA_AAA1;  // bit48 = 1
    localparam logic [63:0] F2 = 64'h5550_0000_0000_0002;  // bit48 = 0

    initial begin
        reset = 1'b1;
        drive(0, 0, 64'd0, 0, 0, 0, 0, 0);
        #1;
        check("rst_count_even", 64'(bus.count_even), 64'd0);
        check("rst_count_odd",  64'(bus.count_odd),  64'd0);
        check("rst_cwri",       64'(bus.cwri),       64'd1);
        check("rst_cwdo_even",  bus.cwdo_even,       64'd0);
        check("rst_proto_err",  64'(bus.proto_err),  64'd0);
        #12 reset = 1'b0;
        @(posedge clk); #1;

        // Route by header bit: cw-bound flit first, then a PE-bound one behind it.
        cyc(1, 1, F1, 1, 0, 0, 0, 0);
        cyc(1, 1, F2, 1, 0, 0, 0, 0);
        drive(0, 0, 64'd0, 0, 1, 1, 0, 0);
        #2 check("t2_cwso_cw", 64'(bus.cwso_cw), 64'd1);
        check("t2_head_a1", bus.cwdo_even, F1);
        tick();
        // Head now PE-bound with PE not ready: cw grant alone must not pop.
        drive(0, 0, 64'd0, 0, 1, 1, 0, 0);
        #2 check("t5_cwso_cw", 64'(bus.cwso_cw), 64'd0);
        check("t5_cwso_pe", 64'(bus.cwso_pe), 64'd0);
        check("t5_head", bus.cwdo_even, F2);
        tick();
        check("t5_count_kept", 64'(bus.count_even), 64'd1);
        cyc(0, 0, 64'd0, 0, 1, 1, 0, 1);
        check("t5_count_kept2", 64'(bus.count_even), 64'd1);
        drive(0, 0, 64'd0, 0, 0, 0, 1, 1);
        #2 check("t2_cwso_pe", 64'(bus.cwso_pe), 64'd1);
        tick();
        check("t2_count_empty", 64'(bus.count_even), 64'd0);

        // Fill odd VC, then overflow it.
        for (int k = 0; k < DEPTH; k++) cyc(0, 1, mk(k[0], 16'h0300 + 16'(k)), 1, 0, 0, 0, 0);
        check("t3_count_full", 64'(bus.count_odd), 64'd4);
        check("t3_cwri_low",   64'(bus.cwri),      64'd0);
        check("t3_err_before", 64'(bus.proto_err), 64'd0);
        cyc(0, 1, 64'hDEAD_BEEF_0000_0005, 0, 0, 0, 0, 0);
        check("t3_err_set",    64'(bus.proto_err), 64'd1);
        check("t3_count_kept", 64'(bus.count_odd), 64'd4);
        for (int k = 0; k < DEPTH; k++) cyc(1, 0, 64'd0, 0, 1, 1, 1, 1);
        check("t3_drained",    64'(bus.count_odd), 64'd0);
        check("t3_err_sticky", 64'(bus.proto_err), 64'd1);

        // Toggle polarity every cycle with continuous traffic and all grants.
        for (int i = 0; i < 12; i++) begin
            cyc(i[0], 1, mk((i % 3) == 0, 16'h0400 + 16'(i)), 1, 1, 1, 1, 1);
            check("t4_even_le2", 64'(bus.count_even <= 2), 64'd1);
            check("t4_odd_le2",  64'(bus.count_odd  <= 2), 64'd1);
        end
        cyc(0, 0, 64'd0, 0, 1, 1, 1, 1);
        cyc(1, 0, 64'd0, 0, 1, 1, 1, 1);
        check("t4_even_empty", 64'(bus.count_even), 64'd0);
        check("t4_odd_empty",  64'(bus.count_odd),  64'd0);

        // Nine flits through the even VC in bursts of three, wrapping pointers.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++)
                cyc(1, 1, mk((r + k) % 2 == 1, 16'h0600 + 16'(3 * r + k)), 1, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) cyc(0, 0, 64'd0, 0, 1, 1, 1, 1);
        end
        check("t6_count_end", 64'(bus.count_even), 64'd0);

        // Reset mid-stream with three flits queued and a live request.
        for (int k = 0; k < 3; k++) cyc(1, 1, mk(1'b1, 16'h0700 + 16'(k)), 1, 0, 0, 0, 0);
        drive(0, 0, 64'd0, 0, 1, 0, 1, 0);
        #2 check("t1_pre_req", 64'(bus.cwso_cw), 64'd1);
        reset = 1'b1;
        #1;
        check("t1_count_even", 64'(bus.count_even), 64'd0);
        check("t1_cwri",       64'(bus.cwri),       64'd1);
        check("t1_cwso_cw",    64'(bus.cwso_cw),    64'd0);
        check("t1_cwso_pe",    64'(bus.cwso_pe),    64'd0);
        check("t1_cwdo_even",  bus.cwdo_even,       64'd0);
        check("t1_cwdo_odd",   bus.cwdo_odd,        64'd0);
        check("t1_proto_err",  64'(bus.proto_err),  64'd0);
        exp_q_even.delete();
        exp_q_odd.delete();
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        cyc(0, 1, F2, 1, 0, 0, 0, 0);
        cyc(1, 0, 64'd0, 0, 0, 0, 1, 1);
        cyc(1, 0, 64'd0, 0, 0, 0, 0, 0);
        check("end_even_q", 64'(exp_q_even.size()), 64'd0);
        check("end_odd_q",  64'(exp_q_odd.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
